// File: rtl/fft_frame_feeder.sv
// Buffers complex samples in a 2^DEPTH_LOG2 FIFO and feeds them to an FFT as gap-free 2^cfg_stages bursts.
// Optional inter-burst idle gap enabled by defining FFT_FEED_GAP_EN (length GAP_CYCLES).
module fft_frame_feeder #(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 9,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_re,
  input  logic [WIDTH-1:0]      s_im,
  input  logic [3:0]            cfg_stages,
  output logic                  do_en,
  output logic [WIDTH-1:0]      do_re,
  output logic [WIDTH-1:0]      do_im,
  output logic [3:0]            do_stages,
  output logic                  frame_start,
  output logic                  cfg_err,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (GAP_CYCLES < 1) begin : g_gap_check
    $error("GAP_CYCLES must be at least 1");
  end

`ifdef FFT_FEED_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2} state_t;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0] gap_cnt;
  logic          gap_done;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;
`endif

  state_t state, state_nxt;

  logic [2*WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [9:0]            n_full;
  logic [8:0]            burst_cnt;
  logic                  cfg_legal, frame_ready, burst_last;
  logic                  push, pop, launch, cfg_bad, first_pop;

  assign s_ready     = ~fifo_count[DEPTH_LOG2];
  assign push        = s_valid & s_ready;
  assign n_full      = 10'd1 << cfg_stages;
  assign cfg_legal   = (cfg_stages >= 4'd2) && (cfg_stages <= 4'd8);
  assign frame_ready = fifo_count >= (DEPTH_LOG2+1)'(n_full);
  assign burst_last  = (burst_cnt == 9'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (launch) state_nxt = BURST;
`ifdef FFT_FEED_GAP_EN
      BURST: if (burst_last) state_nxt = GAP;
      GAP:   if (gap_done) state_nxt = IDLE;
`else
      BURST: if (burst_last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop     = (state == BURST);
    launch  = (state == IDLE) && cfg_legal && frame_ready;
    cfg_bad = (state == IDLE) && !cfg_legal;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_re, s_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      do_en       <= 1'b0;
      do_re       <= '0;
      do_im       <= '0;
      frame_start <= 1'b0;
      do_stages   <= 4'd2;
      cfg_err     <= 1'b0;
      burst_cnt   <= '0;
      first_pop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Burst length is frozen at launch; later cfg_stages changes wait for the next IDLE decision.
      if (launch) begin
        do_stages <= cfg_stages;
        burst_cnt <= 9'(n_full - 10'd1);
        first_pop <= 1'b1;
      end else if (pop) begin
        if (!burst_last) burst_cnt <= burst_cnt - 1'b1;
        first_pop <= 1'b0;
      end

      do_en       <= pop;
      frame_start <= pop & first_pop;
      do_re       <= pop ? mem[rd_ptr][2*WIDTH-1:WIDTH] : '0;
      do_im       <= pop ? mem[rd_ptr][WIDTH-1:0] : '0;
      if (cfg_bad) cfg_err <= 1'b1;
    end
  end

`ifdef FFT_FEED_GAP_EN
  assign gap_done = (gap_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             gap_cnt <= '0;
    else if (pop && burst_last)          gap_cnt <= GW'(GAP_CYCLES - 1);
    else if (state == GAP && !gap_done)  gap_cnt <= gap_cnt - 1'b1;
  end
`endif

endmodule
